// File: rtl/shift_sequencer.sv
// shift_sequencer: round-robin front end for a shared, external 32-bit barrel
// shifter. It accepts one operation at a time from either of two requesters and
// drives the shifter for one pass (SLL/SRL/SRA) or two passes (ROL/ROR, built
// by OR-combining a left and a right shift). It returns a registered,
// single-cycle result pulse to the requester that owns the operation.
//
// Optional build macro: SHIFT_SEQ_PERF_EN adds the perf_ops / perf_rot_ops
// saturating counters and their output ports.

module shift_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [XLEN-1:0]  req0_a,
  input  logic [4:0]       req0_shamt,
  input  logic [2:0]       req0_op,
  output logic             rsp0_valid,
  output logic [XLEN-1:0]  rsp0_result,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [XLEN-1:0]  req1_a,
  input  logic [4:0]       req1_shamt,
  input  logic [2:0]       req1_op,
  output logic             rsp1_valid,
  output logic [XLEN-1:0]  rsp1_result,

  output logic [XLEN-1:0]  sh_a,
  output logic [4:0]       sh_shamt,
  output logic [1:0]       sh_type,
  input  logic [XLEN-1:0]  sh_r
`ifdef SHIFT_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_ops,
  output logic [CNT_W-1:0] perf_rot_ops
`endif
);

  // Operation encodings seen on reqN_op.
  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // Shifter type encodings on sh_type. SH_NONE makes the shifter output 0.
  localparam logic [1:0] SH_LL   = 2'b00;
  localparam logic [1:0] SH_RL   = 2'b01;
  localparam logic [1:0] SH_RA   = 2'b10;
  localparam logic [1:0] SH_NONE = 2'b11;

  // The shift amount port is hard-wired to 5 bits, so only a 32-bit datapath
  // is meaningful. Catch a bad configuration at elaboration time.
  generate
    if (XLEN != 32 || CNT_W < 1) begin : g_param_check
      $error("shift_sequencer: XLEN must be 32 and CNT_W must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_reg;
  logic              last_grant_reg;
  logic              owner_reg;
  logic [XLEN-1:0]   a_reg;
  logic [4:0]        shamt_reg;
  logic [2:0]        op_reg;
  logic [XLEN-1:0]   acc_reg;
  logic [XLEN-1:0]   sh_a_reg;
  logic [4:0]        sh_shamt_reg;
  logic [1:0]        sh_type_reg;

  logic              any_valid;
  logic              accept;
  logic              grant_next;
  logic [XLEN-1:0]   sel_a;
  logic [4:0]        sel_shamt;
  logic [2:0]        sel_op;

  // Type used for the first pass. Rotates start with the shift in their own
  // direction. Illegal codes select the zeroing type.
  function automatic logic [1:0] p1_type(input logic [2:0] op);
    logic [1:0] t;
    case (op)
      OP_SLL, OP_ROL: t = SH_LL;
      OP_SRL, OP_ROR: t = SH_RL;
      OP_SRA:         t = SH_RA;
      default:        t = SH_NONE;
    endcase
    return t;
  endfunction

  // Type used for the second pass of a rotate: the opposite logical shift.
  function automatic logic [1:0] p2_type(input logic [2:0] op);
    return (op == OP_ROL) ? SH_RL : SH_LL;
  endfunction

  function automatic logic is_rot(input logic [2:0] op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

  // Round-robin pick: when both requesters are valid, the one that was not
  // granted last time wins. Otherwise the sole valid requester wins.
  always_comb begin
    grant_next = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_next = ~last_grant_reg;
    end else if (req1_valid) begin
      grant_next = 1'b1;
    end
  end

  assign any_valid  = req0_valid | req1_valid;
  // Acceptance is only possible in IDLE, and never while reset is held.
  assign accept     = (state_reg == IDLE) && any_valid && !rst;
  assign req0_ready = accept && !grant_next;
  assign req1_ready = accept && grant_next;

  assign sel_a      = grant_next ? req1_a     : req0_a;
  assign sel_shamt  = grant_next ? req1_shamt : req0_shamt;
  assign sel_op     = grant_next ? req1_op    : req0_op;

  // Main sequencer: capture the winning request, drive the shifter for one or
  // two passes from registered sh_* outputs, and build up the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      a_reg          <= '0;
      shamt_reg      <= '0;
      op_reg         <= '0;
      acc_reg        <= '0;
      sh_a_reg       <= '0;
      sh_shamt_reg   <= '0;
      sh_type_reg    <= SH_NONE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            owner_reg      <= grant_next;
            last_grant_reg <= grant_next;
            a_reg          <= sel_a;
            shamt_reg      <= sel_shamt;
            op_reg         <= sel_op;
            // Present the first pass to the shifter as P1 begins.
            sh_a_reg       <= sel_a;
            sh_shamt_reg   <= sel_shamt;
            sh_type_reg    <= p1_type(sel_op);
            state_reg      <= P1;
          end
        end
        P1: begin
          acc_reg <= sh_r;
          if (is_rot(op_reg) && (shamt_reg != 5'd0)) begin
            // Second pass shifts the other way by (32 - n) mod 32.
            sh_a_reg     <= a_reg;
            sh_shamt_reg <= 5'd0 - shamt_reg;
            sh_type_reg  <= p2_type(op_reg);
            state_reg    <= P2;
          end else begin
            sh_a_reg     <= '0;
            sh_shamt_reg <= '0;
            sh_type_reg  <= SH_NONE;
            state_reg    <= DONE;
          end
        end
        P2: begin
          acc_reg      <= acc_reg | sh_r;
          sh_a_reg     <= '0;
          sh_shamt_reg <= '0;
          sh_type_reg  <= SH_NONE;
          state_reg    <= DONE;
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign sh_a     = sh_a_reg;
  assign sh_shamt = sh_shamt_reg;
  assign sh_type  = sh_type_reg;

  // Per-requester response registers: a one-cycle pulse following DONE for
  // the owner, with the result held afterwards.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      logic            valid_reg;
      logic [XLEN-1:0] result_reg;
      logic            hit;

      assign hit = (state_reg == DONE) && (owner_reg == 1'(gi));

      // Pulse valid for the owner and capture the finished accumulator.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg  <= 1'b0;
          result_reg <= '0;
        end else begin
          valid_reg <= hit;
          if (hit) begin
            result_reg <= acc_reg;
          end
        end
      end
    end
  endgenerate

  assign rsp0_valid  = g_rsp[0].valid_reg;
  assign rsp0_result = g_rsp[0].result_reg;
  assign rsp1_valid  = g_rsp[1].valid_reg;
  assign rsp1_result = g_rsp[1].result_reg;

`ifdef SHIFT_SEQ_PERF_EN
  logic [CNT_W-1:0] ops_cnt_reg;
  logic [CNT_W-1:0] rot_cnt_reg;

  // Saturating counts of accepted operations and accepted rotates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_cnt_reg <= '0;
      rot_cnt_reg <= '0;
    end else if (accept) begin
      if (ops_cnt_reg != '1) begin
        ops_cnt_reg <= ops_cnt_reg + CNT_W'(1);
      end
      if (is_rot(sel_op) && (rot_cnt_reg != '1)) begin
        rot_cnt_reg <= rot_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign perf_ops     = ops_cnt_reg;
  assign perf_rot_ops = rot_cnt_reg;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer. Models the external barrel shifter, drives
// directed and random operations from both requesters and compares results
// and latencies with a behavioural reference computed from the operation
// definitions (rotates via a doubled operand).

module tb_shift_sequencer;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a;
  logic [4:0]  req0_shamt;
  logic [2:0]  req0_op;
  logic        rsp0_valid;
  logic [31:0] rsp0_result;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a;
  logic [4:0]  req1_shamt;
  logic [2:0]  req1_op;
  logic        rsp1_valid;
  logic [31:0] rsp1_result;
  logic [31:0] sh_a;
  logic [4:0]  sh_shamt;
  logic [1:0]  sh_type;
  logic [31:0] sh_r;
`ifdef SHIFT_SEQ_PERF_EN
  logic [15:0] perf_ops;
  logic [15:0] perf_rot_ops;
`endif

  int total = 0;
  int bad   = 0;

  bit mon_en       = 1'b0;
  bit mon_bad_type = 1'b0;

  shift_sequencer #(.XLEN(32), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_shamt  (req0_shamt),
    .req0_op     (req0_op),
    .rsp0_valid  (rsp0_valid),
    .rsp0_result (rsp0_result),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_shamt  (req1_shamt),
    .req1_op     (req1_op),
    .rsp1_valid  (rsp1_valid),
    .rsp1_result (rsp1_result),
    .sh_a        (sh_a),
    .sh_shamt    (sh_shamt),
    .sh_type     (sh_type),
    .sh_r        (sh_r)
`ifdef SHIFT_SEQ_PERF_EN
    ,
    .perf_ops     (perf_ops),
    .perf_rot_ops (perf_rot_ops)
`endif
  );

  always #5 clk = ~clk;

  // External barrel shifter the DUT drives.
  always_comb begin
    case (sh_type)
      2'b00:   sh_r = sh_a << sh_shamt;
      2'b01:   sh_r = sh_a >> sh_shamt;
      2'b10:   sh_r = 32'($signed(sh_a) >>> sh_shamt);
      default: sh_r = 32'h0;
    endcase
  end

  always @(negedge clk) begin
    if (mon_en && sh_type !== 2'b11) mon_bad_type = 1'b1;
  end

  // Reference: what each operation should return.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [4:0] n);
    logic [63:0]        dbl;
    logic [63:0]        t;
    logic signed [31:0] s;
    dbl = {a, a};
    s   = a;
    case (op)
      3'd0: return a << n;
      3'd1: return a >> n;
      3'd2: return 32'(s >>> n);
      3'd3: begin t = dbl >> (6'd32 - {1'b0, n}); return t[31:0]; end
      3'd4: begin t = dbl >> n; return t[31:0]; end
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [4:0] n);
    return ((op == 3'd3 || op == 3'd4) && n != 5'd0) ? 4 : 3;
  endfunction

  // Issue one operation from requester idx and watch 8 cycles after acceptance.
  task automatic do_op(input int idx, input logic [2:0] op, input logic [31:0] a,
                       input logic [4:0] n, output int lat, output logic [31:0] res,
                       output int own_cnt, output int other_cnt);
    bit acc_ok;
    lat = -1; res = 32'h0; own_cnt = 0; other_cnt = 0; acc_ok = 1'b0;
    @(posedge clk); #1;
    if (idx == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_shamt = n;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_shamt = n;
    end
    for (int i = 0; i < 20 && !acc_ok; i++) begin
      @(negedge clk);
      if ((idx == 0 && req0_ready) || (idx == 1 && req1_ready)) acc_ok = 1'b1;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (acc_ok) begin
      for (int i = 1; i <= 8; i++) begin
        @(negedge clk);
        if ((idx == 0) ? rsp0_valid : rsp1_valid) begin
          own_cnt++;
          if (lat < 0) begin
            lat = i;
            res = (idx == 0) ? rsp0_result : rsp1_result;
          end
        end
        if ((idx == 0) ? rsp1_valid : rsp0_valid) other_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'h1; req0_shamt = 5'd1;
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 32'h2; req1_shamt = 5'd1;
    repeat (2) @(negedge clk);
    total++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_ready got=%b want=00", {req0_ready, req1_ready});
    end
    total++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      bad++; $display("FAIL reset_rsp_valid got=%b want=00", {rsp0_valid, rsp1_valid});
    end
    total++;
    if (rsp0_result !== 32'h0 || rsp1_result !== 32'h0) begin
      bad++; $display("FAIL reset_rsp_result got=%h/%h want=0/0", rsp0_result, rsp1_result);
    end
    total++;
    if (sh_type !== 2'b11 || sh_a !== 32'h0 || sh_shamt !== 5'h0) begin
      bad++; $display("FAIL reset_shifter got type=%b a=%h n=%h want 11/0/0", sh_type, sh_a, sh_shamt);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL reset_first_grant got=%b want=10", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    $display("reset: ready/rsp/shifter idle checked, first grant goes to req0");
  endtask

  task automatic test_single();
    int          idx_t [6] = '{0, 1, 1, 0, 0, 1};
    logic [2:0]  op_t  [6] = '{3'd0, 3'd2, 3'd1, 3'd3, 3'd4, 3'd3};
    logic [31:0] a_t   [6] = '{32'h00000001, 32'h80000000, 32'h80000000,
                               32'h80000001, 32'h00000001, 32'hDEADBEEF};
    logic [4:0]  n_t   [6] = '{5'd4, 5'd31, 5'd31, 5'd1, 5'd4, 5'd0};
    logic [31:0] exp_t [6] = '{32'h00000010, 32'hFFFFFFFF, 32'h00000001,
                               32'h00000003, 32'h10000000, 32'hDEADBEEF};
    int          lat_t [6] = '{3, 3, 3, 4, 4, 3};
    int          lat, own, other;
    logic [31:0] res, held;
    for (int k = 0; k < 6; k++) begin
      do_op(idx_t[k], op_t[k], a_t[k], n_t[k], lat, res, own, other);
      held = (idx_t[k] == 0) ? rsp0_result : rsp1_result;
      total++;
      if (res !== exp_t[k]) begin
        bad++; $display("FAIL single%0d_result got=%h want=%h", k, res, exp_t[k]);
      end
      total++;
      if (lat !== lat_t[k]) begin
        bad++; $display("FAIL single%0d_latency got=%0d want=%0d", k, lat, lat_t[k]);
      end
      total++;
      if (own !== 1) begin
        bad++; $display("FAIL single%0d_pulse_count got=%0d want=1", k, own);
      end
      total++;
      if (other !== 0) begin
        bad++; $display("FAIL single%0d_other_rsp got=%0d want=0", k, other);
      end
      total++;
      if (held !== exp_t[k]) begin
        bad++; $display("FAIL single%0d_result_hold got=%h want=%h", k, held, exp_t[k]);
      end
      $display("single: req%0d op=%0d a=%h n=%0d -> %h lat=%0d", idx_t[k], op_t[k], a_t[k],
               n_t[k], res, lat);
    end
  endtask

  task automatic test_illegal();
    logic [2:0]  ops [3] = '{3'd7, 3'd5, 3'd6};
    int          lat, own, other;
    logic [31:0] res;
    for (int k = 0; k < 3; k++) begin
      mon_bad_type = 1'b0;
      mon_en = 1'b1;
      do_op(k % 2, ops[k], 32'hFFFFFFFF, 5'($urandom_range(0, 31)), lat, res, own, other);
      mon_en = 1'b0;
      total++;
      if (res !== 32'h0) begin
        bad++; $display("FAIL illegal%0d_result got=%h want=00000000", k, res);
      end
      total++;
      if (lat !== 3) begin
        bad++; $display("FAIL illegal%0d_latency got=%0d want=3", k, lat);
      end
      total++;
      if (mon_bad_type !== 1'b0) begin
        bad++; $display("FAIL illegal%0d_sh_type got=non-11 seen want=always 11", k);
      end
      $display("illegal: op=%0d -> %h lat=%0d", ops[k], res, lat);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0]  op0, op1;
    logic [31:0] a0, a1, e;
    logic [4:0]  n0, n1;
    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];
    int          order [$];
    int          both_hi, grants, got0, got1;
    bit          g0, g1;
    both_hi = 0; grants = 0; got0 = 0; got1 = 0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    op0 = 3'($urandom_range(0, 4)); a0 = $urandom; n0 = 5'($urandom_range(0, 31));
    op1 = 3'($urandom_range(0, 4)); a1 = ~a0;     n1 = 5'($urandom_range(0, 31));
    req0_op = op0; req0_a = a0; req0_shamt = n0; req0_valid = 1'b1;
    req1_op = op1; req1_a = a1; req1_shamt = n1; req1_valid = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (rsp0_valid) begin
        e = (exp0.size() > 0) ? exp0.pop_front() : 32'hxxxxxxxx;
        got0++; total++;
        if (rsp0_result !== e) begin
          bad++; $display("FAIL rr_rsp0_result got=%h want=%h", rsp0_result, e);
        end
      end
      if (rsp1_valid) begin
        e = (exp1.size() > 0) ? exp1.pop_front() : 32'hxxxxxxxx;
        got1++; total++;
        if (rsp1_result !== e) begin
          bad++; $display("FAIL rr_rsp1_result got=%h want=%h", rsp1_result, e);
        end
      end
      g0 = req0_ready; g1 = req1_ready;
      if (g0 && g1) both_hi++;
      if (g0) begin order.push_back(0); exp0.push_back(ref_result(op0, a0, n0)); grants++; end
      if (g1) begin order.push_back(1); exp1.push_back(ref_result(op1, a1, n1)); grants++; end
      if (g0 || g1) begin
        $display("rr: grant req%0d (grant #%0d)", g1 ? 1 : 0, grants);
        @(posedge clk); #1;
        if (grants >= 6) begin
          req0_valid = 1'b0; req1_valid = 1'b0;
        end else if (g0) begin
          op0 = 3'($urandom_range(0, 4)); a0 = $urandom; n0 = 5'($urandom_range(0, 31));
          req0_op = op0; req0_a = a0; req0_shamt = n0;
        end else begin
          op1 = 3'($urandom_range(0, 4)); a1 = $urandom; n1 = 5'($urandom_range(0, 31));
          req1_op = op1; req1_a = a1; req1_shamt = n1;
        end
      end
      if (grants >= 6 && got0 + got1 >= 6) break;
    end
    total++;
    if (order.size() !== 6) begin
      bad++; $display("FAIL rr_grant_count got=%0d want=6", order.size());
    end
    for (int k = 0; k < order.size() && k < 6; k++) begin
      total++;
      if (order[k] !== k % 2) begin
        bad++; $display("FAIL rr_order%0d got=%0d want=%0d", k, order[k], k % 2);
      end
    end
    total++;
    if (both_hi !== 0) begin
      bad++; $display("FAIL rr_both_ready got=%0d cycles want=0", both_hi);
    end
    total++;
    if (got0 !== 3 || got1 !== 3) begin
      bad++; $display("FAIL rr_rsp_count got=%0d/%0d want=3/3", got0, got1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_random();
    int          idx, lat, own, other;
    logic [2:0]  op;
    logic [31:0] a, res, e;
    logic [4:0]  n;
    for (int k = 0; k < 24; k++) begin
      idx = int'($urandom_range(0, 1));
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      n   = 5'($urandom_range(0, 31));
      if (k % 6 == 0) n = 5'd0;
      e   = ref_result(op, a, n);
      do_op(idx, op, a, n, lat, res, own, other);
      total++;
      if (res !== e || lat !== ref_latency(op, n) || own !== 1 || other !== 0) begin
        bad++;
        $display("FAIL random%0d got res=%h lat=%0d pulses=%0d/%0d want res=%h lat=%0d pulses=1/0",
                 k, res, lat, own, other, e, ref_latency(op, n));
      end
      $display("random: req%0d op=%0d a=%h n=%0d -> %h lat=%0d", idx, op, a, n, res, lat);
    end
  endtask

  task automatic test_reset_mid();
    bit          acc_ok;
    int          pulses, ready_hi, own, other;
    logic [31:0] res;
    acc_ok = 1'b0; pulses = 0; ready_hi = 0; own = 0; other = 0; res = 32'h0;
    // A req0 rotate leaves req1 as the natural next winner; only reset brings req0 back.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_op = 3'd3; req0_a = 32'h80000001; req0_shamt = 5'd3;
    for (int i = 0; i < 20 && !acc_ok; i++) begin
      @(negedge clk);
      if (req0_ready) acc_ok = 1'b1;
    end
    @(posedge clk); #1; req0_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'h3; req0_shamt = 5'd2;
    req1_valid = 1'b1; req1_op = 3'd1; req1_a = 32'h8; req1_shamt = 5'd1;
    repeat (3) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) pulses++;
      if (req0_ready || req1_ready) ready_hi++;
    end
    total++;
    if (acc_ok !== 1'b1) begin
      bad++; $display("FAIL rmid_rol_accept got=0 want=1");
    end
    total++;
    if (ready_hi !== 0) begin
      bad++; $display("FAIL rmid_ready_in_reset got=%0d cycles want=0", ready_hi);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL rmid_grant_after_reset got=%b want=10", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (rsp0_valid) begin own++; res = rsp0_result; end
      if (rsp1_valid) other++;
    end
    total++;
    if (pulses !== 0 || own !== 1 || other !== 0) begin
      bad++; $display("FAIL rmid_pulses got in_reset=%0d rsp0=%0d rsp1=%0d want 0/1/0",
                      pulses, own, other);
    end
    total++;
    if (res !== 32'h0000000C) begin
      bad++; $display("FAIL rmid_result got=%h want=0000000c", res);
    end
    $display("reset_mid: rotate discarded, req0 regranted, result=%h", res);
  endtask

`ifdef SHIFT_SEQ_PERF_EN
  task automatic test_perf();
    int          lat, own, other;
    logic [31:0] res;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    total++;
    if (perf_ops !== 16'd0 || perf_rot_ops !== 16'd0) begin
      bad++; $display("FAIL perf_reset got=%0d/%0d want=0/0", perf_ops, perf_rot_ops);
    end
    do_op(0, 3'd0, 32'h1, 5'd1, lat, res, own, other);
    do_op(1, 3'd4, 32'h1, 5'd1, lat, res, own, other);
    do_op(0, 3'd2, 32'h80000000, 5'd4, lat, res, own, other);
    total++;
    if (perf_ops !== 16'd3 || perf_rot_ops !== 16'd1) begin
      bad++; $display("FAIL perf_counts got=%0d/%0d want=3/1", perf_ops, perf_rot_ops);
    end
    $display("perf: ops=%0d rot_ops=%0d", perf_ops, perf_rot_ops);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_shamt = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_shamt = '0; req1_op = '0;
    test_reset();
    test_single();
    test_illegal();
    test_round_robin();
    test_random();
    test_reset_mid();
`ifdef SHIFT_SEQ_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
